// File: rtl/arq_rx.sv
// Go-back-N ARQ receiver: classifies incoming link frames, delivers in-order
// payloads through a ready/valid FIFO and emits registered cumulative acks
// (frame-triggered re-acks plus periodic keep-alives once traffic has started).
module arq_rx #(
    parameter int unsigned SEQ_W      = 4,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned ACK_PERIOD = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [SEQ_W-1:0]  in_seq,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_error,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              ack_valid,
    output logic [SEQ_W-1:0]  ack_seq,
    output logic [15:0]       drop_count
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned TMR_W = $clog2(ACK_PERIOD);

    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(ACK_PERIOD - 1);

    typedef enum logic {
        IDLE,
        ACTIVE
    } state_t;

    state_t state;
    state_t state_next;

    logic [SEQ_W-1:0]  expected;
    logic [SEQ_W-1:0]  last_acc;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [TMR_W-1:0]  timer;
    logic [TMR_W-1:0]  timer_next;

    logic              accept;
    logic              drop;
    logic              ack_fire;
    logic [SEQ_W-1:0]  ack_seq_next;
    logic              push;
    logic              pop;

    assign push      = accept;
    assign out_valid = (count != '0);
    assign pop       = out_valid && out_ready;
    assign out_data  = mem[rd_ptr];

    // State register: IDLE until the first accepted frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: ACTIVE is sticky once any frame is accepted.
    always_comb begin
        state_next = state;
        if (accept) begin
            state_next = ACTIVE;
        end
    end

    // Frame classification and ack scheduling for the next cycle.
    always_comb begin
        accept       = 1'b0;
        drop         = 1'b0;
        ack_fire     = 1'b0;
        ack_seq_next = last_acc;
        timer_next   = timer;

        if (in_valid) begin
            if (in_error) begin
                drop = 1'b0 | 1'b1;
            end else if (in_seq != expected) begin
                drop     = 1'b1;
                ack_fire = (state == ACTIVE);
            end else if (count == CNT_FULL) begin
                drop     = 1'b1;
                ack_fire = (state == ACTIVE);
            end else begin
                accept       = 1'b1;
                ack_fire     = 1'b1;
                ack_seq_next = in_seq;
            end
        end

        // Keep-alive only fills cycles where no frame-triggered ack is due.
        if (!ack_fire && (state == ACTIVE) && (timer == TMR_LAST)) begin
            ack_fire = 1'b1;
        end

        if (ack_fire) begin
            timer_next = '0;
        end else if (state == ACTIVE) begin
            timer_next = timer + 1'b1;
        end else begin
            timer_next = '0;
        end
    end

    // Sequence tracking: next expected number and last in-order accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            expected <= '0;
            last_acc <= '1;
        end else if (accept) begin
            expected <= expected + 1'b1;
            last_acc <= in_seq;
        end
    end

    // FIFO storage; contents need no reset because pointers and count do.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Registered ack output and keep-alive timer; ack_seq holds between pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            ack_valid <= 1'b0;
            ack_seq   <= '1;
            timer     <= '0;
        end else begin
            ack_valid <= ack_fire;
            timer     <= timer_next;
            if (ack_fire) begin
                ack_seq <= ack_seq_next;
            end
        end
    end

    // Saturating drop counter covering every drop reason.
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_count <= '0;
        end else if (drop && (drop_count != '1)) begin
            drop_count <= drop_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_arq_rx.sv
// Directed bench for arq_rx: inputs driven and outputs sampled on the falling
// edge, so every check sees the state produced by the preceding rising edge.
module tb_arq_rx;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [3:0]  in_seq;
    logic [31:0] in_data;
    logic        in_error;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        ack_valid;
    logic [3:0]  ack_seq;
    logic [15:0] drop_count;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    arq_rx #(
        .SEQ_W      (4),
        .DATA_W     (32),
        .DEPTH      (4),
        .ACK_PERIOD (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_seq     (in_seq),
        .in_data    (in_data),
        .in_error   (in_error),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .ack_valid  (ack_valid),
        .ack_seq    (ack_seq),
        .drop_count (drop_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] pay(input int i);
        return 32'hA500_0000 | 32'(i);
    endfunction

    // One frame for one cycle; returns on the falling edge after it was sampled.
    task automatic send(input logic [3:0] s, input logic [31:0] d, input logic e);
        in_valid = 1'b1;
        in_seq   = s;
        in_data  = d;
        in_error = e;
        @(negedge clk);
        in_valid = 1'b0;
        in_error = 1'b0;
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        rst      = 1'b1;
        @(negedge clk);
        rst      = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_seq    = '0;
        in_data   = '0;
        in_error  = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        check("rst_out_valid",  32'(out_valid),  32'd0);
        check("rst_ack_valid",  32'(ack_valid),  32'd0);
        check("rst_ack_seq",    32'(ack_seq),    32'hF);
        check("rst_drop_count", 32'(drop_count), 32'd0);
        rst = 1'b0;

        // In-order stream across the sequence wrap, consumer always ready.
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            send(4'(i), pay(i), 1'b0);
            check("t1_ack_valid", 32'(ack_valid), 32'd1);
            check("t1_ack_seq",   32'(ack_seq),   32'(i % 16));
            check("t1_out_valid", 32'(out_valid), 32'd1);
            check("t1_out_data",  out_data,       pay(i));
        end
        @(negedge clk);
        check("t1_drained", 32'(out_valid), 32'd0);
        check("t1_drops",   32'(drop_count), 32'd0);

        // Out-of-order frame: 0,1,3,2.
        do_reset();
        out_ready = 1'b1;
        send(4'd0, pay(20), 1'b0);
        check("t2_ack0",  32'(ack_seq), 32'd0);
        check("t2_head0", out_data,     pay(20));
        send(4'd1, pay(21), 1'b0);
        check("t2_ack1",  32'(ack_seq), 32'd1);
        check("t2_head1", out_data,     pay(21));
        send(4'd3, pay(23), 1'b0);
        check("t2_reack_valid", 32'(ack_valid),  32'd1);
        check("t2_reack_seq",   32'(ack_seq),    32'd1);
        check("t2_drop",        32'(drop_count), 32'd1);
        check("t2_no_deliver3", 32'(out_valid),  32'd0);
        send(4'd2, pay(22), 1'b0);
        check("t2_ack2_valid", 32'(ack_valid), 32'd1);
        check("t2_ack2_seq",   32'(ack_seq),   32'd2);
        check("t2_head2",      out_data,       pay(22));
        @(negedge clk);
        check("t2_drained", 32'(out_valid), 32'd0);

        // Corrupted frame before any accept: silent drop, state stays IDLE.
        do_reset();
        send(4'd0, pay(40), 1'b1);
        check("t3_err_no_ack", 32'(ack_valid),  32'd0);
        check("t3_err_drop",   32'(drop_count), 32'd1);
        send(4'd3, pay(43), 1'b0);
        check("t3_idle_seq_no_ack", 32'(ack_valid),  32'd0);
        check("t3_idle_seq_drop",   32'(drop_count), 32'd2);
        send(4'd0, pay(41), 1'b0);
        check("t3_accept_valid", 32'(ack_valid), 32'd1);
        check("t3_accept_seq",   32'(ack_seq),   32'd0);
        check("t3_accept_head",  out_data,       pay(41));

        // Full FIFO: drops with re-ack; a same-cycle pop does not make room.
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            send(4'(i), pay(10 + i), 1'b0);
            check("t4_ack_valid", 32'(ack_valid), 32'd1);
            check("t4_ack_seq",   32'(ack_seq),   (i < 4) ? 32'(i) : 32'd3);
            check("t4_drops",     32'(drop_count), (i < 4) ? 32'd0 : 32'(i - 3));
        end
        check("t4_head0", out_data, pay(10));
        out_ready = 1'b1;
        send(4'd4, pay(14), 1'b0);
        out_ready = 1'b0;
        check("t4_popfull_ack",  32'(ack_seq),    32'd3);
        check("t4_popfull_drop", 32'(drop_count), 32'd3);
        check("t4_head1",        out_data,        pay(11));
        send(4'd4, pay(14), 1'b0);
        check("t4_resend_valid", 32'(ack_valid),  32'd1);
        check("t4_resend_seq",   32'(ack_seq),    32'd4);
        check("t4_resend_drop",  32'(drop_count), 32'd3);
        out_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            check("t4_drain_valid", 32'(out_valid), 32'd1);
            check("t4_drain_data",  out_data,       pay(10 + k));
            @(negedge clk);
        end
        check("t4_drained", 32'(out_valid), 32'd0);

        // Keep-alive: none while IDLE, then every 16 cycles after an accept.
        do_reset();
        begin
            int acks = 0;
            repeat (40) begin
                @(negedge clk);
                if (ack_valid) acks++;
            end
            check("t5_idle_acks", 32'(acks), 32'd0);
        end
        send(4'd0, pay(30), 1'b0);
        check("t5_first_ack", 32'(ack_valid), 32'd1);
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            check("t5_ka_valid", 32'(ack_valid), (k % 16 == 0) ? 32'd1 : 32'd0);
            if (k % 16 == 0) check("t5_ka_seq", 32'(ack_seq), 32'd0);
        end

        // Reset with entries pending; out_ready high during reset is ignored.
        do_reset();
        out_ready = 1'b0;
        send(4'd0, pay(60), 1'b0);
        send(4'd1, pay(61), 1'b0);
        send(4'd2, pay(62), 1'b0);
        send(4'd2, pay(62), 1'b0);
        check("t6_pre_drop", 32'(drop_count), 32'd1);
        rst       = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        check("t6_out_valid", 32'(out_valid),  32'd0);
        check("t6_ack_valid", 32'(ack_valid),  32'd0);
        check("t6_ack_seq",   32'(ack_seq),    32'hF);
        check("t6_drops",     32'(drop_count), 32'd0);
        rst       = 1'b0;
        out_ready = 1'b0;
        send(4'd0, pay(50), 1'b0);
        check("t6_post_valid", 32'(ack_valid), 32'd1);
        check("t6_post_seq",   32'(ack_seq),   32'd0);
        check("t6_post_head",  out_data,       pay(50));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/arq_rx.md
Name: arq_rx

Overview:
- Go-back-N ARQ receiver at the far end of the data link; peer of the ARQ transmitter that gives the credit/data path its non-lossy link.
- Accepts sequence-numbered frames from the raw link (no backpressure; frames may be corrupted), delivers them in order without duplicates to a ready/valid output FIFO, and emits cumulative acks.
- Acks go through a last-writer-wins register onto the lossy ack channel, so lost acks are repaired by later ack events.

Parameters:
- SEQ_W, 4, sequence number width. Transmitter window must be ≤ 2^SEQ_W-1.
- DATA_W, 32, frame payload width.
- DEPTH, 4, output FIFO depth in entries. Must be ≥1.
- ACK_PERIOD, 16, idle cycles before a keep-alive ack is re-sent. Must be ≥2.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  frame present on link this cycle. Single-cycle, no ready.
- in_seq  in  SEQ_W  frame sequence number.
- in_data  in  DATA_W  frame payload.
- in_error  in  1  frame corrupted, qualified by in_valid.
- out_valid  out  1  output FIFO head valid.
- out_ready  in  1  consumer accepts head.
- out_data  out  DATA_W  output FIFO head payload.
- ack_valid  out  1  single-cycle ack pulse. No backpressure; downstream register keeps last value.
- ack_seq  out  SEQ_W  sequence number of last in-order accepted frame.
- drop_count  out  16  saturating count of dropped frames (all reasons).

Behaviour:
- Reset (synchronous, rst high at a clk edge) sets:
  - expected=0, last_acc=2^SEQ_W-1.
  - FIFO empty, timer=0, state=IDLE.
  - out_valid=0, ack_valid=0, ack_seq=all-ones, drop_count=0.
  - Reset mid-stream discards FIFO contents and any pending ack.
- States:
  - IDLE: no frame accepted since reset.
  - ACTIVE: entered on the first accept; left only by rst.
- Classification of a frame in cycle t (in_valid=1), in priority order:
  1. in_error=1: DROP_ERR. Silent, no ack; in_seq is untrusted.
  2. in_seq≠expected: DROP_SEQ (duplicate or out-of-order).
  3. FIFO count==DEPTH at start of cycle t: DROP_FULL. A pop in the same cycle does not create space.
  4. Otherwise ACCEPT.
- On ACCEPT:
  - Push in_data into the FIFO.
  - expected ← expected+1 mod 2^SEQ_W; last_acc ← in_seq.
  - state ← ACTIVE.
- Ack generation, registered; the ack appears in cycle t+1:
  - After ACCEPT: ack_valid=1, ack_seq=in_seq.
  - After DROP_SEQ or DROP_FULL while ACTIVE: ack_valid=1, ack_seq=last_acc (re-ack repairs lost acks).
  - After DROP_SEQ or DROP_FULL while IDLE: no ack.
  - Keep-alive: while ACTIVE, timer increments on every cycle with no ack emitted and clears on any ack emission. When timer==ACK_PERIOD-1, the next cycle emits ack_valid=1 with ack_seq=last_acc, and timer clears.
  - Frame-triggered acks take priority over keep-alive and replace it. At most one ack per cycle.
  - ack_seq holds its last value when ack_valid=0.
- Output FIFO:
  - Standard ready/valid; transfer when out_valid&&out_ready.
  - A frame accepted in cycle t is visible at the head in cycle t+1 if the FIFO was empty.
  - out_data is stable while out_valid&&!out_ready.
  - Simultaneous push and pop is allowed. Count is updated as count+push-pop.
  - Order is strictly sequence order; no payload is duplicated or lost after ACCEPT.
- drop_count increments by 1 on any DROP_* and saturates at 0xFFFF.
- Wrap-around: sequence arithmetic is mod 2^SEQ_W. expected goes 2^SEQ_W-1 → 0 with no special handling.
- out_ready is ignored during rst.

Test Plan:
- In-order stream, seq 0..19 (wraps past 15), out_ready=1 → out_data matches all 20 in order; ack_seq pulses 0,1,…,15,0,1,2,3, each one cycle after its frame.
- Seq 0,1,3,2: → frame 3 dropped, re-ack ack_seq=1, drop_count=1; frame 2 accepted, ack_seq=2; only 0,1,2 delivered.
- Frame seq 0 with in_error=1, then seq 0 clean → first frame dropped with no ack (state stays IDLE); second frame accepted with ack_seq=0.
- out_ready=0, send seq 0..5 (DEPTH=4) → 0..3 accepted; 4 and 5 DROP_FULL, each re-acked with ack_seq=3; drop_count=2. Resend 4 after one pop → accepted.
- After accepting seq 0, idle for 40 cycles → keep-alive acks with ack_seq=0 at ACK_PERIOD spacing (timer cleared by each). In IDLE after reset, no ack is emitted for 40 cycles.
- Assert rst with 3 FIFO entries pending → next cycle out_valid=0, ack_seq=all-ones, drop_count=0; a following seq 0 frame is accepted.
